or1200_if_queue: RTL and testbench
==================================

Name: or1200_if_queue

Overview:
Parametrised successor to the single-slot instruction-fetch stage. It generalises the one saved-instruction register into a DEPTH-entry FIFO. Each entry holds {insn, pc, err[2:0]}. The block sits between the instruction cache (IC) CPU port and the decode stage. It absorbs IC responses while the pipeline is frozen, back-pressures the IC, and injects NOPs on flush, delay-slot kill and rfe.

Parameters:
DEPTH, 4, number of queue entries; power of 2, >=2
DW, 32, instruction width
AW, 32, fetch address width; bits [1:0] are forced to 0 on stored and presented PCs
LW, $clog2(DEPTH+1), width of the fill-level output (derived, not overridable)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, asynchronous, active-low; asserted when rst==0
icpu_dat_i  in  DW  instruction data from IC
icpu_ack_i  in  1  IC response valid with data
icpu_err_i  in  1  IC response valid with error
icpu_adr_i  in  AW  address of the current IC response
icpu_tag_i  in  4  error tag: 4'hd=TLB miss, 4'hc=page fault, 4'hb=bus error
icpu_rdy_o  out  1  queue can accept a response this cycle
if_freeze  in  1  decode stall; no pop this cycle
if_flushpipe  in  1  discard all queued and incoming entries
no_more_dslot  in  1  kill delay slot: force NOP, mask exceptions
rfe  in  1  return from exception: force NOP
if_insn  out  DW  instruction presented to decode
if_pc  out  AW  PC of if_insn
if_stall  out  1  no valid instruction available
except_itlbmiss  out  1  head entry carries a TLB miss
except_immufault  out  1  head entry carries a page fault
except_ibuserr  out  1  head entry carries a bus error
if_level  out  LW  number of occupied entries
if_ovf  out  1  sticky overflow flag; cleared only by reset

Behaviour:
- Reset (rst==0, async): queue empty, pointers 0, if_level=0, if_ovf=0. Combinational outputs with an empty queue and no response: if_insn=32'h15610000, if_pc={icpu_adr_i[AW-1:2],2'b00}, if_stall=1, all except_* =0, icpu_rdy_o=1.
- resp = icpu_ack_i | icpu_err_i.
- Head selection:
  - queue non-empty: head = oldest entry;
  - queue empty and resp: head = bypass of the incoming response (zero latency);
  - otherwise: no head.
- if_stall = no head.
- if_insn priority:
  1. no_more_dslot | rfe | if_flushpipe -> 32'h15410000;
  2. head present -> head insn;
  3. otherwise -> 32'h15610000.
- Error responses are stored and bypassed with insn = 32'h15410000.
- except_*:
  - 0 when no_more_dslot or when there is no head;
  - otherwise the head's err bits; for a bypass, icpu_err_i & (icpu_tag_i==tag).
- if_pc = head pc when a head exists, else {icpu_adr_i[AW-1:2],2'b00}.
- pop = head & !if_freeze & !if_flushpipe. Consuming a bypassed head means the response is never written.
- push = resp & !if_flushpipe & !(bypass consumed) & !full_eff, where full_eff = (if_level==DEPTH) & !pop.
- Push and pop in the same cycle: if_level is unchanged and pointers wrap modulo DEPTH.
- icpu_rdy_o = (if_level < DEPTH) | !if_freeze. The IC must not respond while it is low.
- Overflow: resp & !if_flushpipe & full_eff & !(bypass consumed) -> response dropped, if_ovf <= 1 (sticky).
- if_flushpipe at an edge: pointers reset, if_level <= 0, the incoming response is discarded. Flush takes priority over push, pop and overflow.
- no_more_dslot and rfe only mask outputs. They do not pop, and the head stays queued until a cycle with !if_freeze.
- Reset asserted mid-operation empties the queue immediately. No partial entry survives.

Test Plan:
1. Bypass: reset, queue empty, if_freeze=0, icpu_ack_i=1, dat=32'hA8200001, adr=32'h100 -> same cycle if_insn=32'hA8200001, if_pc=32'h100, if_stall=0; if_level stays 0.
2. Fill/back-pressure: if_freeze=1, 4 acks at 0x200..0x20C (DEPTH=4) -> if_level=4, icpu_rdy_o=0. Release freeze -> insns popped in order, one per cycle, PCs 0x200,0x204,0x208,0x20C; then if_stall=1.
3. Simultaneous push/pop at full: level 4, if_freeze=0, ack at 0x210 -> if_level remains 4, if_ovf=0; pointer wraps correctly, so 0x210 emerges 4 pops later.
4. Error tags: frozen, icpu_err_i=1 with tag 4'hd, 4'hc, 4'hb -> on release, except_itlbmiss, except_immufault and except_ibuserr assert in turn, each with if_insn=32'h15410000. With no_more_dslot=1 all three read 0.
5. Flush: level 3, if_flushpipe=1 with concurrent ack -> if_insn=32'h15410000 that cycle; next cycle if_level=0, if_stall=1; the concurrent response is not stored.
6. Overflow and reset: level 4, if_freeze=1, forced ack -> if_ovf=1, level stays 4. Drive rst=0 asynchronously mid-cycle -> if_level=0 and if_ovf=0 without waiting for a clock edge.

Source files
------------

// File: rtl/or1200_if_queue.sv
`default_nettype none
// ============================================================================
// Module      : or1200_if_queue
// Description : Instruction-fetch queue between the IC CPU port and decode.
//               A DEPTH-entry FIFO of {insn, pc, err} that absorbs IC responses
//               while decode is frozen, back-pressures the IC, bypasses a
//               response straight to decode when the queue is empty, and
//               injects NOPs on flush, delay-slot kill and rfe.
// Revision    : 1.0 - initial release
// ============================================================================
module or1200_if_queue #(
    parameter int  DEPTH = 4,
    parameter int  DW    = 32,
    parameter int  AW    = 32,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] icpu_dat_i,
    input  logic          icpu_ack_i,
    input  logic          icpu_err_i,
    input  logic [AW-1:0] icpu_adr_i,
    input  logic [3:0]    icpu_tag_i,
    output logic          icpu_rdy_o,
    input  logic          if_freeze,
    input  logic          if_flushpipe,
    input  logic          no_more_dslot,
    input  logic          rfe,
    output logic [DW-1:0] if_insn,
    output logic [AW-1:0] if_pc,
    output logic          if_stall,
    output logic          except_itlbmiss,
    output logic          except_immufault,
    output logic          except_ibuserr,
    output logic [LW-1:0] if_level,
    output logic          if_ovf
);

    localparam int            PW          = $clog2(DEPTH);
    localparam logic [DW-1:0] C_NOP_KILL  = DW'(32'h15410000);
    localparam logic [DW-1:0] C_NOP_IDLE  = DW'(32'h15610000);
    localparam logic [LW-1:0] C_DEPTH     = LW'(DEPTH);
    localparam logic [PW-1:0] C_PTR_ONE   = PW'(1);
    localparam logic [3:0]    C_TAG_TLB   = 4'hd;
    localparam logic [3:0]    C_TAG_PF    = 4'hc;
    localparam logic [3:0]    C_TAG_BUS   = 4'hb;

    // Queue storage; err bit order is {tlb miss, page fault, bus error}
    logic [DW-1:0] r_insn_mem [DEPTH];
    logic [AW-3:0] r_pc_mem   [DEPTH];
    logic [2:0]    r_err_mem  [DEPTH];

    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [LW-1:0] r_level;
    logic          r_ovf;

    logic          w_resp;
    logic          w_empty;
    logic          w_full;
    logic          w_head;
    logic          w_bypass;
    logic          w_pop;
    logic          w_qpop;
    logic          w_bypass_used;
    logic          w_full_eff;
    logic          w_push;
    logic          w_ovf_set;
    logic [DW-1:0] w_in_insn;
    logic [2:0]    w_in_err;
    logic [DW-1:0] w_head_insn;
    logic [AW-3:0] w_head_pc;
    logic [2:0]    w_head_err;

    // Queue control: head selection, pop/push/overflow decisions
    always_comb begin
        w_resp        = icpu_ack_i | icpu_err_i;
        w_empty       = (r_level == '0);
        w_full        = (r_level == C_DEPTH);
        w_head        = !w_empty | w_resp;
        w_bypass      = w_empty & w_resp;
        w_pop         = w_head & !if_freeze & !if_flushpipe;
        w_qpop        = w_pop & !w_empty;
        w_bypass_used = w_pop & w_bypass;
        w_full_eff    = w_full & !w_pop;
        w_push        = w_resp & !if_flushpipe & !w_bypass_used & !w_full_eff;
        w_ovf_set     = w_resp & !if_flushpipe & w_full_eff & !w_bypass_used;
    end

    // Incoming response as it would be stored: errors become a kill NOP
    always_comb begin
        w_in_insn = icpu_err_i ? C_NOP_KILL : icpu_dat_i;
        w_in_err  = {3{icpu_err_i}} & {icpu_tag_i == C_TAG_TLB,
                                       icpu_tag_i == C_TAG_PF,
                                       icpu_tag_i == C_TAG_BUS};
    end

    // Head entry: oldest queued entry, otherwise the bypassed response
    always_comb begin
        w_head_insn = w_in_insn;
        w_head_pc   = icpu_adr_i[AW-1:2];
        w_head_err  = w_in_err;
        if (!w_empty) begin
            w_head_insn = r_insn_mem[r_rd_ptr];
            w_head_pc   = r_pc_mem[r_rd_ptr];
            w_head_err  = r_err_mem[r_rd_ptr];
        end
    end

    // Decode-facing outputs with kill/idle NOP injection
    always_comb begin
        if_stall         = !w_head;
        if_pc            = {icpu_adr_i[AW-1:2], 2'b00};
        if_insn          = C_NOP_IDLE;
        except_itlbmiss  = 1'b0;
        except_immufault = 1'b0;
        except_ibuserr   = 1'b0;
        if (w_head) begin
            if_pc   = {w_head_pc, 2'b00};
            if_insn = w_head_insn;
            if (!no_more_dslot) begin
                except_itlbmiss  = w_head_err[2];
                except_immufault = w_head_err[1];
                except_ibuserr   = w_head_err[0];
            end
        end
        if (no_more_dslot | rfe | if_flushpipe) begin
            if_insn = C_NOP_KILL;
        end
        icpu_rdy_o = (r_level < C_DEPTH) | !if_freeze;
        if_level   = r_level;
        if_ovf     = r_ovf;
    end

    // Pointers, fill level and sticky overflow; flush wins over everything
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
        end else if (if_flushpipe) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_qpop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            r_level <= r_level + {{(LW-1){1'b0}}, w_push} - {{(LW-1){1'b0}}, w_qpop};
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Entry storage write; contents are don't-care until the level covers them
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_insn_mem[r_wr_ptr] <= w_in_insn;
            r_pc_mem[r_wr_ptr]   <= icpu_adr_i[AW-1:2];
            r_err_mem[r_wr_ptr]  <= w_in_err;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_or1200_if_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_or1200_if_queue
// Description : Self-checking bench for or1200_if_queue: directed scenarios
//               followed by random traffic, compared against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_or1200_if_queue;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int LW    = $clog2(DEPTH + 1);

    localparam logic [31:0] C_NOP_KILL = 32'h15410000;
    localparam logic [31:0] C_NOP_IDLE = 32'h15610000;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] icpu_dat_i;
    logic          icpu_ack_i;
    logic          icpu_err_i;
    logic [AW-1:0] icpu_adr_i;
    logic [3:0]    icpu_tag_i;
    logic          icpu_rdy_o;
    logic          if_freeze;
    logic          if_flushpipe;
    logic          no_more_dslot;
    logic          rfe;
    logic [DW-1:0] if_insn;
    logic [AW-1:0] if_pc;
    logic          if_stall;
    logic          except_itlbmiss;
    logic          except_immufault;
    logic          except_ibuserr;
    logic [LW-1:0] if_level;
    logic          if_ovf;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] insn;
        logic [31:0] pc;
        logic [2:0]  err;
    } ent_t;

    ent_t m_q[$];
    logic m_ovf = 1'b0;

    or1200_if_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_dut (
        .clk              (clk),
        .rst              (rst),
        .icpu_dat_i       (icpu_dat_i),
        .icpu_ack_i       (icpu_ack_i),
        .icpu_err_i       (icpu_err_i),
        .icpu_adr_i       (icpu_adr_i),
        .icpu_tag_i       (icpu_tag_i),
        .icpu_rdy_o       (icpu_rdy_o),
        .if_freeze        (if_freeze),
        .if_flushpipe     (if_flushpipe),
        .no_more_dslot    (no_more_dslot),
        .rfe              (rfe),
        .if_insn          (if_insn),
        .if_pc            (if_pc),
        .if_stall         (if_stall),
        .except_itlbmiss  (except_itlbmiss),
        .except_immufault (except_immufault),
        .except_ibuserr   (except_ibuserr),
        .if_level         (if_level),
        .if_ovf           (if_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // The response currently on the IC port, as the queue should see it
    function automatic ent_t incoming();
        ent_t e;
        e.insn = icpu_err_i ? C_NOP_KILL : icpu_dat_i;
        e.pc   = {icpu_adr_i[31:2], 2'b00};
        e.err  = icpu_err_i ? {icpu_tag_i == 4'hd, icpu_tag_i == 4'hc, icpu_tag_i == 4'hb}
                            : 3'b000;
        return e;
    endfunction

    task automatic idle_inputs();
        icpu_ack_i    = 1'b0;
        icpu_err_i    = 1'b0;
        icpu_dat_i    = $urandom;
        icpu_adr_i    = $urandom;
        icpu_tag_i    = 4'h0;
        if_freeze     = 1'b0;
        if_flushpipe  = 1'b0;
        no_more_dslot = 1'b0;
        rfe           = 1'b0;
    endtask

    task automatic set_resp(input logic ack, input logic err, input logic [31:0] adr,
                            input logic [3:0] tag);
        icpu_ack_i = ack;
        icpu_err_i = err;
        icpu_adr_i = adr;
        icpu_tag_i = tag;
        icpu_dat_i = $urandom;
    endtask

    // Compare all outputs mid-cycle, then advance one clock and update the model
    task automatic step();
        logic resp, has_head, pop, byp_used, full_eff, was_empty;
        ent_t hd;
        #4;
        resp      = icpu_ack_i | icpu_err_i;
        was_empty = (m_q.size() == 0);
        has_head  = !was_empty || resp;
        hd        = was_empty ? incoming() : m_q[0];
        check("stall", 64'(if_stall), 64'(!has_head));
        check("insn", 64'(if_insn),
              64'((no_more_dslot || rfe || if_flushpipe) ? C_NOP_KILL :
                  has_head ? hd.insn : C_NOP_IDLE));
        check("pc", 64'(if_pc), 64'(has_head ? hd.pc : {icpu_adr_i[31:2], 2'b00}));
        check("except", 64'({except_itlbmiss, except_immufault, except_ibuserr}),
              64'((no_more_dslot || !has_head) ? 3'b000 : hd.err));
        check("rdy", 64'(icpu_rdy_o), 64'((m_q.size() < DEPTH) || !if_freeze));
        check("level", 64'(if_level), 64'(m_q.size()));
        check("ovf", 64'(if_ovf), 64'(m_ovf));
        @(posedge clk);
        if (!rst) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else if (if_flushpipe) begin
            m_q.delete();
        end else begin
            pop      = has_head && !if_freeze;
            byp_used = pop && was_empty;
            full_eff = (m_q.size() == DEPTH) && !pop;
            if (pop && !was_empty) void'(m_q.pop_front());
            if (resp && !byp_used) begin
                if (full_eff) m_ovf = 1'b1;
                else          m_q.push_back(hd.insn === 'x ? incoming() : incoming());
            end
        end
        #1;
    endtask

    task automatic fill(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            if_freeze = 1'b1;
            set_resp(1'b1, 1'b0, base + 32'(4 * i), 4'h0);
            step();
        end
        set_resp(1'b0, 1'b0, 32'h0, 4'h0);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        #1;
        check("reset_level", 64'(if_level), 64'(0));
        check("reset_ovf", 64'(if_ovf), 64'(0));
        step();
        step();
        rst = 1'b1;
        step();

        // Zero-latency bypass into an empty queue
        set_resp(1'b1, 1'b0, 32'h100, 4'h0);
        icpu_dat_i = 32'hA8200001;
        #4;
        check("t1_insn", 64'(if_insn), 64'(32'hA8200001));
        check("t1_pc", 64'(if_pc), 64'(32'h100));
        #1;
        step();
        idle_inputs();
        step();

        // Fill to capacity under freeze, then drain in order
        fill(DEPTH, 32'h200);
        step();
        if_freeze = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) step();

        // Push and pop together at full; wrap-around ordering
        fill(DEPTH, 32'h300);
        if_freeze = 1'b0;
        set_resp(1'b1, 1'b0, 32'h210, 4'h0);
        step();
        set_resp(1'b0, 1'b0, 32'h0, 4'h0);
        for (int i = 0; i < DEPTH + 2; i++) step();

        // Error tags, first masked by delay-slot kill, then exposed in turn
        if_freeze = 1'b1;
        set_resp(1'b0, 1'b1, 32'h400, 4'hd); step();
        set_resp(1'b0, 1'b1, 32'h404, 4'hc); step();
        set_resp(1'b0, 1'b1, 32'h408, 4'hb); step();
        set_resp(1'b0, 1'b0, 32'h0, 4'h0);
        no_more_dslot = 1'b1; step();
        no_more_dslot = 1'b0; rfe = 1'b1; step();
        rfe = 1'b0; if_freeze = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // Flush with a concurrent response
        fill(3, 32'h500);
        if_flushpipe = 1'b1;
        set_resp(1'b1, 1'b0, 32'h510, 4'h0);
        step();
        idle_inputs();
        step();

        // Overflow on a forced response, then asynchronous reset mid-cycle
        fill(DEPTH, 32'h600);
        if_freeze = 1'b1;
        set_resp(1'b1, 1'b0, 32'h610, 4'h0);
        step();
        set_resp(1'b0, 1'b0, 32'h0, 4'h0);
        step();
        check("t6_ovf", 64'(if_ovf), 64'(1));
        #2;
        rst = 1'b0;
        #1;
        check("t6_async_level", 64'(if_level), 64'(0));
        check("t6_async_ovf", 64'(if_ovf), 64'(0));
        m_q.delete();
        m_ovf = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle_inputs();
        step();

        // Random traffic; the IC only responds when the queue is ready
        for (int c = 0; c < 400; c++) begin
            logic [3:0] tags [4];
            logic       ready;
            tags          = '{4'hd, 4'hc, 4'hb, 4'h0};
            if_freeze     = ($urandom_range(0, 99) < 50);
            if_flushpipe  = ($urandom_range(0, 99) < 5);
            no_more_dslot = ($urandom_range(0, 99) < 10);
            rfe           = ($urandom_range(0, 99) < 10);
            ready         = (m_q.size() < DEPTH) || !if_freeze;
            icpu_dat_i    = $urandom;
            icpu_adr_i    = $urandom;
            icpu_tag_i    = tags[$urandom_range(0, 3)];
            icpu_ack_i    = 1'b0;
            icpu_err_i    = 1'b0;
            if (ready && ($urandom_range(0, 99) < 60)) begin
                if ($urandom_range(0, 99) < 20) icpu_err_i = 1'b1;
                else                            icpu_ack_i = 1'b1;
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
